// File: rtl/audio_fifo_pkg.sv
// Shared constants for the AHB-Lite audio FIFO: register offsets (word index taken
// from HADDR[4:2]) and bit positions inside the STATUS and CTRL registers.
package audio_fifo_pkg;

  localparam logic [2:0] DATA_OFF   = 3'd0;
  localparam logic [2:0] STATUS_OFF = 3'd1;
  localparam logic [2:0] LEVEL_OFF  = 3'd2;
  localparam logic [2:0] CTRL_OFF   = 3'd3;
  localparam logic [2:0] THRESH_OFF = 3'd4;

  localparam int unsigned STAT_EMPTY    = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_OVERRUN  = 2;
  localparam int unsigned STAT_UNDERRUN = 3;
  localparam int unsigned STAT_THR      = 4;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_CLR = 1;
  localparam int unsigned CTRL_IE  = 2;

endpackage

// File: rtl/ahbl_audio_fifo_if.sv
// AHB-Lite slave-side bus bundle for the audio FIFO.
//   master modport: drives address/control/write data, receives HREADYOUT/HRDATA.
//   slave modport : the reverse.
interface ahbl_audio_fifo_if;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HADDR, HTRANS, HSIZE, HWRITE, HREADY, HSEL, HWDATA,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HWRITE, HREADY, HSEL, HWDATA,
    output HREADYOUT, HRDATA
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear.
//   clear_i : resets pointers and level; overrides push/pop in the same cycle.
//   push_i  : write data_i (ignored when full unless a pop happens too).
//   pop_i   : drop the head entry (ignored when empty).
//   head_o  : combinational head entry; full_o/empty_o/level_o from registered level.
module sync_fifo #(
  parameter  int unsigned Depth  = 16,
  parameter  int unsigned Width  = 24,
  localparam int unsigned AddrW  = $clog2(Depth),
  localparam int unsigned LevelW = AddrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [Width-1:0]  data_i,
  input  logic              pop_i,
  output logic [Width-1:0]  head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LevelW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i) & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      // Pointers wrap naturally because Depth is a power of two.
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      level_d = level_q + LevelW'(do_push) - LevelW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; the level gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/ahbl_audio_fifo.sv
// AHB-Lite slave buffering I2S PCM samples for burst draining by firmware.
//   HCLK/HRESETn : clock, asynchronous active-low reset.
//   ahb          : AHB-Lite slave bundle (zero wait state, HREADYOUT tied 1).
//   sample_valid/sample_data : one-cycle sample strobe from the I2S receiver.
//   irq          : level interrupt, IE & (THR | OVERRUN).
// Registers: DATA (pop), STATUS (W1C sticky flags), LEVEL, CTRL, THRESH.
module ahbl_audio_fifo
  import audio_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SAMPLE_W = 24
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahbl_audio_fifo_if.slave    ahb,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                irq
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  // Address-phase capture.
  logic [2:0]    addr_q;
  logic          write_q, valid_q;

  logic          en_q, en_d, ie_q, ie_d;
  logic [LW-1:0] thresh_q, thresh_d;
  logic          overrun_q, overrun_d, underrun_q, underrun_d;

  logic [SAMPLE_W-1:0] head;
  logic          full, empty, thr;
  logic [LW-1:0] level;
  logic          wr, rd_data, pop, push_req, clr;
  logic          overrun_set, underrun_set, wr_status, wr_ctrl, wr_thresh;
  logic [31:0]   status, ctrl_rd, rdata;

  logic unused_bus;
  assign unused_bus = ^{ahb.HSIZE, ahb.HADDR, ahb.HWDATA, ahb.HTRANS[0]};

  assign ahb.HREADYOUT = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else if (ahb.HREADY) begin
      valid_q <= ahb.HSEL & ahb.HTRANS[1];
      write_q <= ahb.HWRITE;
      addr_q  <= ahb.HADDR[4:2];
    end
  end

  // Data-phase commits happen on the edge where HREADY ends the phase.
  assign wr        = valid_q & write_q & ahb.HREADY;
  assign rd_data   = valid_q & ~write_q & ahb.HREADY & (addr_q == DATA_OFF);
  assign wr_status = wr & (addr_q == STATUS_OFF);
  assign wr_ctrl   = wr & (addr_q == CTRL_OFF);
  assign wr_thresh = wr & (addr_q == THRESH_OFF);

  assign pop          = rd_data & ~empty;
  assign underrun_set = rd_data & empty;
  assign push_req     = sample_valid & en_q;
  assign overrun_set  = push_req & full & ~pop;
  assign clr          = wr_ctrl & ahb.HWDATA[CTRL_CLR];

  sync_fifo #(
    .Depth (DEPTH),
    .Width (SAMPLE_W)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .clear_i (clr),
    .push_i  (push_req),
    .data_i  (sample_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign thr = (level >= thresh_q);

  always_comb begin
    en_d       = en_q;
    ie_d       = ie_q;
    thresh_d   = thresh_q;
    // A new event in the same cycle as its W1C wins.
    overrun_d  = (overrun_q & ~(wr_status & ahb.HWDATA[STAT_OVERRUN])) | overrun_set;
    underrun_d = (underrun_q & ~(wr_status & ahb.HWDATA[STAT_UNDERRUN])) | underrun_set;
    if (wr_ctrl) begin
      en_d = ahb.HWDATA[CTRL_EN];
      ie_d = ahb.HWDATA[CTRL_IE];
    end
    if (wr_thresh) thresh_d = ahb.HWDATA[LW-1:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      thresh_q   <= LW'(DEPTH / 2);
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      en_q       <= en_d;
      ie_q       <= ie_d;
      thresh_q   <= thresh_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_EMPTY]    = empty;
    status[STAT_FULL]     = full;
    status[STAT_OVERRUN]  = overrun_q;
    status[STAT_UNDERRUN] = underrun_q;
    status[STAT_THR]      = thr;
    ctrl_rd               = '0;
    ctrl_rd[CTRL_EN]      = en_q;
    ctrl_rd[CTRL_IE]      = ie_q;
    rdata                 = '0;
    if (valid_q && !write_q) begin
      case (addr_q)
        DATA_OFF:   rdata = empty ? 32'h0 : 32'(signed'(head));
        STATUS_OFF: rdata = status;
        LEVEL_OFF:  rdata = 32'(level);
        CTRL_OFF:   rdata = ctrl_rd;
        THRESH_OFF: rdata = 32'(thresh_q);
        default:    rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA = rdata;
  assign irq        = ie_q & (thr | overrun_q);

endmodule

// File: tb/tb_ahbl_audio_fifo.sv
module tb_ahbl_audio_fifo;

  localparam int DEPTH = 16;
  localparam int SW    = 24;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          sample_valid;
  logic [SW-1:0] sample_data;
  logic          irq;

  ahbl_audio_fifo_if bus ();

  ahbl_audio_fifo #(
    .DEPTH    (DEPTH),
    .SAMPLE_W (SW)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .ahb          (bus.slave),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .irq          (irq)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_q[$];
  bit m_en = 0, m_ie = 0, m_ovr = 0, m_und = 0;
  int m_thresh = DEPTH / 2;
  bit m_dv = 0, m_dw = 0;
  int m_da = 0;

  function automatic int sext(logic [SW-1:0] d);
    int v;
    v = int'(d);
    if (v >= (1 << (SW - 1))) v = v - (1 << SW);
    return v;
  endfunction

  function automatic logic [31:0] exp_rdata();
    int n;
    n = m_q.size();
    case (m_da)
      0: return (n > 0) ? m_q[0] : 0;
      1: return (n == 0 ? 1 : 0) + (n == DEPTH ? 2 : 0) + (m_ovr ? 4 : 0) + (m_und ? 8 : 0)
              + (n >= m_thresh ? 16 : 0);
      2: return n;
      3: return (m_en ? 1 : 0) + (m_ie ? 4 : 0);
      4: return m_thresh;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_irq();
    return m_ie && ((m_q.size() >= m_thresh) || m_ovr);
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    bit rd, wr, pop, preq, full, ovr_set, und_set, clr;
    if (!HRESETn) begin
      m_q.delete();
      m_en = 0; m_ie = 0; m_ovr = 0; m_und = 0;
      m_thresh = DEPTH / 2;
      m_dv = 0; m_dw = 0; m_da = 0;
    end else begin
      rd      = m_dv && !m_dw && (m_da == 0);
      wr      = m_dv && m_dw;
      pop     = rd && (m_q.size() > 0);
      und_set = rd && (m_q.size() == 0);
      preq    = sample_valid && m_en;
      full    = (m_q.size() == DEPTH);
      ovr_set = preq && full && !pop;
      clr     = wr && (m_da == 3) && bus.HWDATA[1];
      if (wr && m_da == 1) begin
        if (bus.HWDATA[2]) m_ovr = 0;
        if (bus.HWDATA[3]) m_und = 0;
      end
      if (ovr_set) m_ovr = 1;
      if (und_set) m_und = 1;
      if (clr) m_q.delete();
      else begin
        if (pop) void'(m_q.pop_front());
        if (preq && !ovr_set) m_q.push_back(sext(sample_data));
      end
      if (wr && m_da == 3) begin
        m_en = bus.HWDATA[0];
        m_ie = bus.HWDATA[2];
      end
      if (wr && m_da == 4) m_thresh = int'(bus.HWDATA[4:0]);
      if (bus.HREADY) begin
        m_dv = bus.HSEL && bus.HTRANS[1];
        m_dw = bus.HWRITE;
        m_da = int'(bus.HADDR[4:2]);
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      check("hreadyout", 32'(bus.HREADYOUT), 32'd1);
      check("irq_model", 32'(irq), 32'(exp_irq()));
      if (m_dv && !m_dw) check("hrdata_model", bus.HRDATA, exp_rdata());
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HADDR = '0; bus.HWRITE = 0;
    bus.HSIZE = 3'd2; bus.HREADY = 1; bus.HWDATA = '0;
    sample_valid = 0; sample_data = '0;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    idle();
  endtask

  task automatic addr_phase(logic w, logic [7:0] off);
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HADDR = {24'h0, off}; bus.HWRITE = w;
  endtask

  task automatic push(logic [SW-1:0] d);
    tick();
    sample_valid = 1;
    sample_data  = d;
  endtask

  task automatic rd(logic [7:0] off, output logic [31:0] r, input bit with_push,
                    input logic [SW-1:0] pd);
    tick();
    addr_phase(0, off);
    tick();
    if (with_push) begin
      sample_valid = 1;
      sample_data  = pd;
    end
    @(negedge HCLK);
    r = bus.HRDATA;
  endtask

  task automatic rd_check(string name, logic [7:0] off, logic [31:0] exp);
    logic [31:0] r;
    rd(off, r, 0, '0);
    check(name, r, exp);
  endtask

  task automatic wr(logic [7:0] off, logic [31:0] data);
    tick();
    addr_phase(1, off);
    tick();
    bus.HWDATA = data;
  endtask

  // Pipelined DATA reads, one per cycle; expects base, base+1, ...
  task automatic burst(int n, logic [31:0] base);
    tick();
    addr_phase(0, 8'h00);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i < n - 1) addr_phase(0, 8'h00);
      @(negedge HCLK);
      check($sformatf("burst_%0d", i), bus.HRDATA, base + 32'(i));
    end
  endtask

  initial begin
    logic [31:0] r;
    idle();
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1;
    @(negedge HCLK);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    rd_check("rst_status", 8'h04, 32'h1);
    rd_check("rst_level", 8'h08, 32'h0);
    rd_check("rst_thresh", 8'h10, 32'd8);

    // Sign extension and FIFO order.
    wr(8'h0C, 32'h1);
    push(24'h7FFFFF);
    push(24'h800000);
    push(24'h000005);
    rd_check("data0", 8'h00, 32'h007FFFFF);
    rd_check("data1", 8'h00, 32'hFF800000);
    rd_check("data2", 8'h00, 32'h00000005);
    rd_check("level_drained", 8'h08, 32'h0);
    rd_check("status_drained", 8'h04, 32'h1);

    // Overflow: 17 pushes into 16 entries.
    for (int i = 0; i < 17; i++) push(24'(32'h100 + i));
    rd_check("status_full_ovr", 8'h04, 32'h16);
    rd_check("level_full", 8'h08, 32'd16);
    check("model_level_full", 32'(m_q.size()), 32'd16);
    burst(16, 32'h100);
    rd_check("level_after_burst", 8'h08, 32'h0);
    rd_check("status_ovr_sticky", 8'h04, 32'h5);
    wr(8'h04, 32'h4);
    rd_check("status_ovr_cleared", 8'h04, 32'h1);

    // Full FIFO, push coincides with a DATA pop.
    for (int i = 0; i < 16; i++) push(24'(32'h200 + i));
    rd(8'h00, r, 1, 24'h210);
    check("full_pop_data", r, 32'h200);
    rd_check("full_pop_level", 8'h08, 32'd16);
    rd_check("full_pop_status", 8'h04, 32'h12);
    burst(16, 32'h201);

    // Threshold interrupt.
    wr(8'h10, 32'd4);
    wr(8'h0C, 32'h5);
    push(24'h1);
    push(24'h2);
    push(24'h3);
    tick();
    @(negedge HCLK);
    check("irq_below_thr", 32'(irq), 32'd0);
    push(24'h4);
    tick();
    @(negedge HCLK);
    check("irq_at_thr", 32'(irq), 32'd1);
    rd_check("irq_pop_data", 8'h00, 32'h1);
    tick();
    @(negedge HCLK);
    check("irq_after_pop", 32'(irq), 32'd0);
    burst(3, 32'h2);
    wr(8'h0C, 32'h1);

    // Underrun.
    rd_check("underrun_data", 8'h00, 32'h0);
    rd_check("underrun_status", 8'h04, 32'h9);
    wr(8'h04, 32'h8);
    rd_check("underrun_cleared", 8'h04, 32'h1);

    // CLR with entries queued.
    for (int i = 0; i < 5; i++) push(24'(32'h300 + i));
    rd_check("level_before_clr", 8'h08, 32'd5);
    wr(8'h0C, 32'h3);
    rd_check("level_after_clr", 8'h08, 32'h0);
    rd_check("status_after_clr", 8'h04, 32'h1);
    rd_check("ctrl_clr_reads0", 8'h0C, 32'h1);

    // EN=0 ignores samples.
    wr(8'h0C, 32'h0);
    push(24'hABCDEF);
    push(24'h123456);
    push(24'h000001);
    rd_check("level_disabled", 8'h08, 32'h0);
    rd_check("unmapped_read", 8'h14, 32'h0);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
